ir_command_receiver: RTL and testbench

//  Rover-side decoder for the IR move-command link driven by the main FSM's

---
 rtl/ir_link_defs.sv | 60 ++++++
 rtl/ir_pulse_timer.sv | 77 +++++++
 rtl/ir_command_receiver.sv | 149 ++++++++++++++
 tb/tb_ir_command_receiver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_link_defs.sv
// Shared IR move-command link definitions.
// Used by the rover-side receiver and the main-FPGA IR transmitter: tick and
// width constants, frame length, command field split, receiver state encoding,
// and width-window helpers.
package ir_link_defs;

    // 27 MHz clock / 75 us sample tick
    localparam int unsigned TICK_CYCLES_DEF = 2025;

    // Nominal widths in ticks and the +/- tolerance applied to every window
    localparam int unsigned START_TICKS = 32;
    localparam int unsigned ONE_TICKS   = 16;
    localparam int unsigned ZERO_TICKS  = 8;
    localparam int unsigned TOL_TICKS   = 3;

    // Width counter size (saturates at all-ones)
    localparam int unsigned WIDTH_W = 6;

    // Frame: 12 data bits, LSB first
    localparam int unsigned FRAME_BITS = 12;

    // Command field split {angle, distance}
    localparam int unsigned ANGLE_MSB = 11;
    localparam int unsigned ANGLE_LSB = 8;
    localparam int unsigned DIST_MSB  = 7;
    localparam int unsigned DIST_LSB  = 0;

    typedef logic [WIDTH_W-1:0]    width_t;
    typedef logic [FRAME_BITS-1:0] cmd_t;

    typedef struct packed {
        logic [ANGLE_MSB-ANGLE_LSB:0] angle;
        logic [DIST_MSB-DIST_LSB:0]   distance;
    } move_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SPACE,
        ST_MARK,
        ST_DONE,
        ST_ERR
    } rx_state_t;

    // True when w lies within nominal +/- TOL_TICKS. Written to avoid
    // unsigned underflow on the lower bound.
    function automatic logic in_window(input width_t w, input int unsigned nominal);
        int unsigned wv;
        wv = {{(32-WIDTH_W){1'b0}}, w};
        return ((wv + TOL_TICKS) >= nominal) && (wv <= (nominal + TOL_TICKS));
    endfunction

    // True when w exceeds the upper edge of the nominal window.
    function automatic logic above_window(input width_t w, input int unsigned nominal);
        int unsigned wv;
        wv = {{(32-WIDTH_W){1'b0}}, w};
        return wv > (nominal + TOL_TICKS);
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// IR pulse timer: synchronizes the demodulated IR input, detects edges and
// measures edge-to-edge widths in sample ticks.
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous, active-high
//   ir_in  in   raw demodulated IR (asynchronous)
//   rise   out  one-cycle pulse on a synchronized rising edge
//   fall   out  one-cycle pulse on a synchronized falling edge
//   width  out  ticks elapsed since the previous edge, saturating at 63
module ir_pulse_timer
    import ir_link_defs::*;
#(
    parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEF
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   ir_in,
    output logic   rise,
    output logic   fall,
    output width_t width
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q,  prev_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    width_t           width_q, width_d;
    logic             edge_det;
    logic             tick;

    assign rise     = sync2_q & ~prev_q;
    assign fall     = ~sync2_q & prev_q;
    assign edge_det = rise | fall;
    assign tick     = (tick_cnt_q == CNT_W'(TICK_CYCLES - 1));
    assign width    = width_q;

    // The divider restarts at 1 rather than 0 so that the edge cycle itself
    // counts toward the first tick: a pulse of exactly N*TICK_CYCLES clocks
    // then reads as width N at the closing edge.
    always_comb begin
        sync1_d    = ir_in;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        tick_cnt_d = tick_cnt_q;
        width_d    = width_q;
        if (edge_det) begin
            tick_cnt_d = CNT_W'(1);
            width_d    = '0;
        end else if (tick) begin
            tick_cnt_d = '0;
            if (width_q != '1) begin
                width_d = width_q + width_t'(1);
            end
        end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            tick_cnt_q <= '0;
            width_q    <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            tick_cnt_q <= tick_cnt_d;
            width_q    <= width_d;
        end
    end

endmodule

// File: rtl/ir_command_receiver.sv
// Rover-side IR move-command receiver. Decodes a start mark followed by 12
// space/mark bit cells (LSB first, long mark = 1, short mark = 0) into the
// command {angle[3:0], distance[7:0]}.
// Ports:
//   clock          in   system clock (27 MHz)
//   reset          in   asynchronous, active-high
//   ir_in          in   demodulated IR, 1 = carrier present (async)
//   move_command   out  last good command {angle, distance}
//   command_valid  out  one-cycle pulse when move_command updates
//   rx_busy        out  high from accepted start mark until frame end/abort
//   rx_error       out  one-cycle pulse on a malformed frame
module ir_command_receiver
    import ir_link_defs::*;
#(
    parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ir_in,
    output logic [FRAME_BITS-1:0] move_command,
    output logic                  command_valid,
    output logic                  rx_busy,
    output logic                  rx_error
);

    logic      rise;
    logic      fall;
    width_t    width;

    rx_state_t state_q, state_d;
    cmd_t      shift_q, shift_d;
    cmd_t      cmd_q,   cmd_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic      pend_q,  pend_d;
    logic      mark_bit;
    logic      mark_ok;

    ir_pulse_timer #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .ir_in (ir_in),
        .rise  (rise),
        .fall  (fall),
        .width (width)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cmd_d     = cmd_q;
        bit_cnt_d = bit_cnt_q;
        pend_d    = pend_q;
        mark_bit  = 1'b0;
        mark_ok   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A rise seen during DONE/ERR was held in pend_q; the width
                // counter already restarted on that edge.
                if (rise || pend_q) begin
                    state_d = ST_START;
                    pend_d  = 1'b0;
                end
            end

            ST_START: begin
                if (fall) begin
                    if (in_window(width, START_TICKS)) begin
                        state_d   = ST_SPACE;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_SPACE: begin
                if (rise) begin
                    state_d = in_window(width, ZERO_TICKS) ? ST_MARK : ST_ERR;
                end else if (above_window(width, ZERO_TICKS)) begin
                    state_d = ST_ERR;
                end
            end

            ST_MARK: begin
                if (fall) begin
                    if (in_window(width, ONE_TICKS)) begin
                        mark_bit = 1'b1;
                        mark_ok  = 1'b1;
                    end else if (in_window(width, ZERO_TICKS)) begin
                        mark_bit = 1'b0;
                        mark_ok  = 1'b1;
                    end
                    if (mark_ok) begin
                        shift_d = {mark_bit, shift_q[FRAME_BITS-1:1]};
                        if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                            // Command is registered on entry to DONE so the
                            // new value and the valid strobe appear together.
                            cmd_d   = {mark_bit, shift_q[FRAME_BITS-1:1]};
                            state_d = ST_DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            state_d   = ST_SPACE;
                        end
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (width == '1) begin
                    state_d = ST_ERR;
                end
            end

            ST_DONE, ST_ERR: begin
                if (rise) begin
                    pend_d = 1'b1;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            cmd_q     <= '0;
            bit_cnt_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cmd_q     <= cmd_d;
            bit_cnt_q <= bit_cnt_d;
            pend_q    <= pend_d;
        end
    end

    assign move_command  = cmd_q;
    assign command_valid = (state_q == ST_DONE);
    assign rx_error      = (state_q == ST_ERR);
    assign rx_busy       = (state_q == ST_SPACE) || (state_q == ST_MARK);

endmodule

// File: tb/tb_ir_command_receiver.sv
// Self-checking bench for ir_command_receiver. Frames are described as lists
// of tick widths; a frame-level model classifies each frame from the width
// windows and pushes the expected outcome into a queue that a negedge monitor
// drains whenever the DUT pulses command_valid or rx_error.
module tb_ir_command_receiver;

    localparam int TB_TICK = 4;

    localparam int START_NOM = 32;
    localparam int ONE_NOM   = 16;
    localparam int ZERO_NOM  = 8;
    localparam int TOL       = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ir_in = 1'b0;
    logic [11:0] move_command;
    logic        command_valid;
    logic        rx_busy;
    logic        rx_error;

    always #5 clock = ~clock;

    ir_command_receiver #(
        .TICK_CYCLES (TB_TICK)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ir_in         (ir_in),
        .move_command  (move_command),
        .command_valid (command_valid),
        .rx_busy       (rx_busy),
        .rx_error      (rx_error)
    );

    typedef struct {
        bit          is_err;
        logic [11:0] cmd;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          n_valid     = 0;
    int          n_error     = 0;
    bit          busy_seen   = 1'b0;
    bit          probe_busy  = 1'b0;
    logic [11:0] last_good   = '0;

    int f_start;
    int f_sp[12];
    int f_mk[12];
    int f_gap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic bit in_win(input int w, input int nom);
        return (w >= nom - TOL) && (w <= nom + TOL);
    endfunction

    // Frame-level reference: decide the outcome purely from the widths.
    task automatic predict();
        logic [11:0] val;
        exp_t        e;
        val = '0;
        if (!in_win(f_start, START_NOM)) return;
        for (int i = 0; i < 12; i++) begin
            if (!in_win(f_sp[i], ZERO_NOM)) begin
                e.is_err = 1'b1; e.cmd = last_good; exp_q.push_back(e);
                return;
            end
            if (in_win(f_mk[i], ONE_NOM))       val[i] = 1'b1;
            else if (in_win(f_mk[i], ZERO_NOM)) val[i] = 1'b0;
            else begin
                e.is_err = 1'b1; e.cmd = last_good; exp_q.push_back(e);
                return;
            end
        end
        e.is_err = 1'b0; e.cmd = val; exp_q.push_back(e);
        last_good = val;
    endtask

    task automatic seg(input logic lvl, input int ticks);
        ir_in = lvl;
        repeat (ticks * TB_TICK) @(posedge clock);
        #1;
    endtask

    task automatic set_nominal(input logic [11:0] v);
        f_start = START_NOM;
        for (int i = 0; i < 12; i++) begin
            f_sp[i] = ZERO_NOM;
            f_mk[i] = v[i] ? ONE_NOM : ZERO_NOM;
        end
        f_gap = 10;
    endtask

    task automatic set_edges(input logic [11:0] v, input bit upper);
        f_start = upper ? START_NOM + TOL : START_NOM - TOL;
        for (int i = 0; i < 12; i++) begin
            f_sp[i] = upper ? ZERO_NOM + TOL : ZERO_NOM - TOL;
            if (v[i]) f_mk[i] = upper ? ONE_NOM + TOL : ONE_NOM - TOL;
            else      f_mk[i] = upper ? ZERO_NOM + TOL : ZERO_NOM - TOL;
        end
        f_gap = 10;
    endtask

    task automatic send_frame();
        predict();
        seg(1'b1, f_start);
        for (int i = 0; i < 12; i++) begin
            seg(1'b0, f_sp[i]);
            if (i == 0 && probe_busy) check("busy_mid_frame", 32'(rx_busy), 32'd1);
            seg(1'b1, f_mk[i]);
        end
        seg(1'b0, f_gap);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every output event must match the head of the expected queue.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (rx_busy) busy_seen = 1'b1;
            if (command_valid) n_valid++;
            if (rx_error) n_error++;
            if (command_valid || rx_error) begin
                check("valid_err_exclusive", 32'(command_valid & rx_error), 32'd0);
                check("busy_at_event", 32'(rx_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_event: valid=%0b err=%0b cmd=%0h, expected no event",
                             command_valid, rx_error, move_command);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_err", 32'(rx_error), 32'(e.is_err));
                    check("move_command", 32'(move_command), 32'(e.cmd));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int v0;
        int e0;
        int kind;
        int k;
        logic [11:0] d;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_move_command", 32'(move_command), 32'd0);
        check("reset_valid", 32'(command_valid), 32'd0);
        check("reset_busy", 32'(rx_busy), 32'd0);
        check("reset_error", 32'(rx_error), 32'd0);
        reset = 1'b0;
        seg(1'b0, 4);

        // 1: nominal 12'h730
        v0 = n_valid; e0 = n_error;
        set_nominal(12'h730);
        probe_busy = 1'b1;
        send_frame();
        probe_busy = 1'b0;
        wait_drain();
        check("t1_cmd", 32'(move_command), 32'h730);
        check("t1_valid_count", 32'(n_valid - v0), 32'd1);
        check("t1_error_count", 32'(n_error - e0), 32'd0);

        // 2: back-to-back 12'h107, 12'h120
        v0 = n_valid;
        set_nominal(12'h107); f_gap = ZERO_NOM;
        send_frame();
        set_nominal(12'h120);
        send_frame();
        wait_drain();
        check("t2_valid_count", 32'(n_valid - v0), 32'd2);
        check("t2_cmd", 32'(move_command), 32'h120);

        // 3: short start mark is silent noise
        v0 = n_valid; e0 = n_error; busy_seen = 1'b0;
        set_nominal(12'h5A5); f_start = 20;
        send_frame();
        wait_drain();
        check("t3_no_valid", 32'(n_valid - v0), 32'd0);
        check("t3_no_error", 32'(n_error - e0), 32'd0);
        check("t3_busy_never", 32'(busy_seen), 32'd0);

        // 4: bit-5 mark too long -> error, command kept
        e0 = n_error;
        set_nominal(12'hFFF); f_mk[5] = 24;
        send_frame();
        wait_drain();
        check("t4_error_count", 32'(n_error - e0), 32'd1);
        check("t4_cmd_kept", 32'(move_command), 32'h120);

        // 5: tolerance edges, both sides
        set_edges(12'hA5C, 1'b1);
        send_frame();
        wait_drain();
        check("t5_upper_cmd", 32'(move_command), 32'hA5C);
        set_nominal(12'h000);
        send_frame();
        set_edges(12'hA5C, 1'b0);
        send_frame();
        wait_drain();
        check("t5_lower_cmd", 32'(move_command), 32'hA5C);

        // Randomized frames with occasional malformed widths
        for (int n = 0; n < 16; n++) begin
            d = 12'($urandom);
            kind = int'($urandom_range(0, 7));
            f_start = int'($urandom_range(START_NOM - TOL, START_NOM + TOL));
            for (int i = 0; i < 12; i++) begin
                f_sp[i] = int'($urandom_range(ZERO_NOM - TOL, ZERO_NOM + TOL));
                f_mk[i] = d[i] ? int'($urandom_range(ONE_NOM - TOL, ONE_NOM + TOL))
                               : int'($urandom_range(ZERO_NOM - TOL, ZERO_NOM + TOL));
            end
            f_gap = int'($urandom_range(8, 14));
            k = int'($urandom_range(0, 11));
            if (kind == 0) f_start = ($urandom_range(0, 1) != 0) ? int'($urandom_range(20, 26))
                                                                  : int'($urandom_range(37, 45));
            if (kind == 1) f_sp[k] = int'($urandom_range(12, 15));
            if (kind == 2) f_mk[k] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(20, 26))
                                                                  : int'($urandom_range(1, 3));
            send_frame();
            wait_drain();
        end

        // 6: reset during bit 6, then a clean frame
        set_nominal(12'h0F0);
        seg(1'b1, f_start);
        for (int i = 0; i < 6; i++) begin
            seg(1'b0, f_sp[i]);
            seg(1'b1, f_mk[i]);
        end
        seg(1'b0, ZERO_NOM);
        ir_in = 1'b1;
        repeat (5 * TB_TICK) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("t6_rst_cmd", 32'(move_command), 32'd0);
        check("t6_rst_valid", 32'(command_valid), 32'd0);
        check("t6_rst_busy", 32'(rx_busy), 32'd0);
        check("t6_rst_error", 32'(rx_error), 32'd0);
        ir_in = 1'b0;
        exp_q.delete();
        last_good = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        seg(1'b0, 4);
        check("t6_post_cmd", 32'(move_command), 32'd0);
        check("t6_post_busy", 32'(rx_busy), 32'd0);
        v0 = n_valid;
        set_nominal(12'h3C3);
        send_frame();
        wait_drain();
        check("t6_valid_count", 32'(n_valid - v0), 32'd1);
        check("t6_cmd", 32'(move_command), 32'h3C3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
